// File: rtl/program_sequencer_mc_if.sv
// rtl/program_sequencer_mc_if.sv - decoder/ROM/cache-side bus of program_sequencer_mc (miss_count with PS_MISS_COUNT_EN)
interface program_sequencer_mc_if #(
   parameter int PC_WIDTH   = 8,
   parameter int JMP_WIDTH  = 4,
   parameter int WORDS_LOG2 = 5,
   parameter int LINES_LOG2 = 1
);
   logic                             sync_reset;
   logic [JMP_WIDTH-1:0]             jmp_addr;
   logic                             jmp;
   logic                             jmp_nz;
   logic                             dont_jmp;
   logic [PC_WIDTH-1:0]              pc;
   logic                             hold_out;
   logic [PC_WIDTH-1:0]              rom_address;
   logic                             cache_wren;
   logic [LINES_LOG2+WORDS_LOG2-1:0] cache_wroffset;
   logic [LINES_LOG2+WORDS_LOG2-1:0] cache_rdoffset;
`ifdef PS_MISS_COUNT_EN
   logic [15:0]                      miss_count;

   modport master (
      input  sync_reset, jmp_addr, jmp, jmp_nz, dont_jmp,
      output pc, hold_out, rom_address, cache_wren, cache_wroffset, cache_rdoffset, miss_count
   );
   modport slave (
      output sync_reset, jmp_addr, jmp, jmp_nz, dont_jmp,
      input  pc, hold_out, rom_address, cache_wren, cache_wroffset, cache_rdoffset, miss_count
   );
`else
   modport master (
      input  sync_reset, jmp_addr, jmp, jmp_nz, dont_jmp,
      output pc, hold_out, rom_address, cache_wren, cache_wroffset, cache_rdoffset
   );
   modport slave (
      output sync_reset, jmp_addr, jmp, jmp_nz, dont_jmp,
      input  pc, hold_out, rom_address, cache_wren, cache_wroffset, cache_rdoffset
   );
`endif
endinterface

// File: rtl/program_sequencer_mc.sv
// rtl/program_sequencer_mc.sv - program sequencer with direct-mapped instruction cache and ROM line fill
// Optional miss counter enabled by defining PS_MISS_COUNT_EN.
module program_sequencer_mc #(
   parameter int PC_WIDTH   = 8,
   parameter int JMP_WIDTH  = 4,
   parameter int WORDS_LOG2 = 5,
   parameter int LINES_LOG2 = 1
) (
   input  logic clk,
   input  logic reset_n,
   program_sequencer_mc_if.master bus
);
   localparam int OFF_W  = LINES_LOG2 + WORDS_LOG2;
   localparam int TAG_W  = PC_WIDTH - OFF_W;
   localparam int NLINES = 1 << LINES_LOG2;
   localparam logic [WORDS_LOG2-1:0] LAST_K = '1;

   typedef enum logic [1:0] {RUN, FILL, DRAIN} state_t;

   state_t                 state, state_nx;
   logic [PC_WIDTH-1:0]    pc_q, pm_addr, miss_addr;
   logic [WORDS_LOG2-1:0]  k;
   logic [TAG_W-1:0]       tags [NLINES];
   logic [NLINES-1:0]      valid;
   logic                   reset_pending;
   logic                   hit;
   logic                   wren_q;
   logic [OFF_W-1:0]       wroffset_q, rdoffset_q;
   logic [LINES_LOG2-1:0]  pm_line, miss_line;
   logic [TAG_W-1:0]       pm_tag, miss_tag;
`ifdef PS_MISS_COUNT_EN
   logic [15:0]            miss_cnt;
   assign bus.miss_count = miss_cnt;
`endif

   assign pm_line   = pm_addr[OFF_W-1:WORDS_LOG2];
   assign pm_tag    = pm_addr[PC_WIDTH-1:OFF_W];
   assign miss_line = miss_addr[OFF_W-1:WORDS_LOG2];
   assign miss_tag  = miss_addr[PC_WIDTH-1:OFF_W];

   always_comb begin
      pm_addr = pc_q + PC_WIDTH'(1);
      if (reset_pending)
         pm_addr = '0;
      else if (bus.jmp | (bus.jmp_nz & ~bus.dont_jmp))
         pm_addr = {bus.jmp_addr, {(PC_WIDTH-JMP_WIDTH){1'b0}}};
   end

   assign hit = valid[pm_line] && (tags[pm_line] == pm_tag);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= RUN;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         RUN:     if (!hit) state_nx = FILL;
         FILL:    if (k == LAST_K) state_nx = DRAIN;
         DRAIN:   state_nx = RUN;
         default: state_nx = RUN;
      endcase
      if (bus.sync_reset) state_nx = RUN;
   end

   always_comb begin
      bus.hold_out = bus.sync_reset | (state != RUN) | ~hit;
      if (state == FILL)
         bus.rom_address = {miss_addr[PC_WIDTH-1:WORDS_LOG2], k};
      else
         bus.rom_address = {pm_addr[PC_WIDTH-1:WORDS_LOG2], {WORDS_LOG2{1'b0}}};
   end

   // The write stage trails FILL by one register to line up with ROM read latency.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_q          <= '0;
         miss_addr     <= '0;
         k             <= '0;
         valid         <= '0;
         reset_pending <= 1'b1;
         wren_q        <= 1'b0;
         wroffset_q    <= '0;
         rdoffset_q    <= '0;
         for (int i = 0; i < NLINES; i++) tags[i] <= '0;
`ifdef PS_MISS_COUNT_EN
         miss_cnt      <= '0;
`endif
      end else if (bus.sync_reset) begin
         valid         <= '0;
         reset_pending <= 1'b1;
         pc_q          <= '0;
         wren_q        <= 1'b0;
         k             <= '0;
`ifdef PS_MISS_COUNT_EN
         miss_cnt      <= '0;
`endif
      end else begin
         wren_q     <= (state == FILL);
         wroffset_q <= {miss_line, k};
         case (state)
            RUN: begin
               if (hit) begin
                  pc_q          <= pm_addr;
                  rdoffset_q    <= pm_addr[OFF_W-1:0];
                  reset_pending <= 1'b0;
               end else begin
                  miss_addr <= pm_addr;
                  k         <= '0;
`ifdef PS_MISS_COUNT_EN
                  if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
`endif
               end
            end
            FILL: k <= k + WORDS_LOG2'(1);
            DRAIN: begin
               valid[miss_line] <= 1'b1;
               tags[miss_line]  <= miss_tag;
               pc_q             <= miss_addr;
               rdoffset_q       <= miss_addr[OFF_W-1:0];
               reset_pending    <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.pc             = pc_q;
   assign bus.cache_wren     = wren_q;
   assign bus.cache_wroffset = wroffset_q;
   assign bus.cache_rdoffset = rdoffset_q;
endmodule

// File: tb/tb_program_sequencer_mc.sv
// tb/tb_program_sequencer_mc.sv - directed self-checking bench for program_sequencer_mc
module tb_program_sequencer_mc;
   logic clk = 1'b0;
   logic reset_n;
   int   n_checks = 0;
   int   n_fail = 0;

   program_sequencer_mc_if #(.PC_WIDTH(8), .JMP_WIDTH(4), .WORDS_LOG2(5), .LINES_LOG2(1)) bus ();

   program_sequencer_mc #(.PC_WIDTH(8), .JMP_WIDTH(4), .WORDS_LOG2(5), .LINES_LOG2(1)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus.master)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_fill(input logic [7:0] base);
      logic [7:0] a;
      logic [5:0] o;
      n_checks++; if (bus.hold_out !== 1'b1) begin n_fail++; $display("FAIL detect_hold got %b want 1", bus.hold_out); end
      n_checks++; if (bus.rom_address !== base) begin n_fail++; $display("FAIL detect_rom got %h want %h", bus.rom_address, base); end
      for (int i = 0; i < 32; i++) begin
         cyc();
         a = base + 8'(i);
         n_checks++; if (bus.hold_out !== 1'b1) begin n_fail++; $display("FAIL fill_hold i=%0d got %b want 1", i, bus.hold_out); end
         n_checks++; if (bus.rom_address !== a) begin n_fail++; $display("FAIL fill_rom i=%0d got %h want %h", i, bus.rom_address, a); end
         n_checks++; if (bus.cache_wren !== (i != 0)) begin n_fail++; $display("FAIL fill_wren i=%0d got %b want %b", i, bus.cache_wren, (i != 0)); end
         if (i > 0) begin
            o = base[5:0] + 6'(i - 1);
            n_checks++; if (bus.cache_wroffset !== o) begin n_fail++; $display("FAIL fill_wroff i=%0d got %h want %h", i, bus.cache_wroffset, o); end
         end
      end
      cyc();
      o = base[5:0] + 6'd31;
      n_checks++; if (bus.hold_out !== 1'b1) begin n_fail++; $display("FAIL drain_hold got %b want 1", bus.hold_out); end
      n_checks++; if (bus.cache_wren !== 1'b1) begin n_fail++; $display("FAIL drain_wren got %b want 1", bus.cache_wren); end
      n_checks++; if (bus.cache_wroffset !== o) begin n_fail++; $display("FAIL drain_wroff got %h want %h", bus.cache_wroffset, o); end
      cyc();
      n_checks++; if (bus.pc !== base) begin n_fail++; $display("FAIL post_fill_pc got %h want %h", bus.pc, base); end
      n_checks++; if (bus.hold_out !== 1'b0) begin n_fail++; $display("FAIL post_fill_hold got %b want 0", bus.hold_out); end
      n_checks++; if (bus.cache_wren !== 1'b0) begin n_fail++; $display("FAIL post_fill_wren got %b want 0", bus.cache_wren); end
      n_checks++; if (bus.cache_rdoffset !== base[5:0]) begin n_fail++; $display("FAIL post_fill_rdoff got %h want %h", bus.cache_rdoffset, base[5:0]); end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      bus.sync_reset = 1'b0; bus.jmp = 1'b0; bus.jmp_nz = 1'b0; bus.dont_jmp = 1'b0; bus.jmp_addr = 4'h0;
      repeat (2) cyc();
      n_checks++; if (bus.pc !== 8'h00) begin n_fail++; $display("FAIL reset_pc got %h want 00", bus.pc); end
      n_checks++; if (bus.hold_out !== 1'b1) begin n_fail++; $display("FAIL reset_hold got %b want 1", bus.hold_out); end
      n_checks++; if (bus.cache_wren !== 1'b0) begin n_fail++; $display("FAIL reset_wren got %b want 0", bus.cache_wren); end
      n_checks++; if (bus.cache_wroffset !== 6'h00) begin n_fail++; $display("FAIL reset_wroff got %h want 00", bus.cache_wroffset); end
      n_checks++; if (bus.cache_rdoffset !== 6'h00) begin n_fail++; $display("FAIL reset_rdoff got %h want 00", bus.cache_rdoffset); end
      n_checks++; if (bus.rom_address !== 8'h00) begin n_fail++; $display("FAIL reset_rom got %h want 00", bus.rom_address); end
`ifdef PS_MISS_COUNT_EN
      n_checks++; if (bus.miss_count !== 16'h0000) begin n_fail++; $display("FAIL reset_miss_count got %h want 0000", bus.miss_count); end
`endif
      reset_n = 1'b1;
      #1;
      test_fill(8'h00);
   endtask

   task automatic test_sequential();
      for (int i = 1; i < 32; i++) begin
         cyc();
         n_checks++; if (bus.pc !== 8'(i)) begin n_fail++; $display("FAIL seq_pc got %h want %h", bus.pc, 8'(i)); end
         n_checks++; if (bus.hold_out !== (i == 31)) begin n_fail++; $display("FAIL seq_hold pc=%0d got %b want %b", i, bus.hold_out, (i == 31)); end
      end
      test_fill(8'h20);
   endtask

   task automatic test_jump_resident();
      bus.jmp = 1'b1; bus.jmp_addr = 4'h0;
      #1;
      n_checks++; if (bus.hold_out !== 1'b0) begin n_fail++; $display("FAIL jres_hold got %b want 0", bus.hold_out); end
      cyc();
      n_checks++; if (bus.pc !== 8'h00) begin n_fail++; $display("FAIL jres_pc got %h want 00", bus.pc); end
      n_checks++; if (bus.hold_out !== 1'b0) begin n_fail++; $display("FAIL jres_hold2 got %b want 0", bus.hold_out); end
      bus.jmp = 1'b0;
      cyc();
      n_checks++; if (bus.pc !== 8'h01) begin n_fail++; $display("FAIL jres_next_pc got %h want 01", bus.pc); end
   endtask

   task automatic test_evict();
      bus.jmp = 1'b1; bus.jmp_addr = 4'h4;
      #1;
      n_checks++; if (bus.hold_out !== 1'b1) begin n_fail++; $display("FAIL evict_miss got %b want 1", bus.hold_out); end
      test_fill(8'h40);
      bus.jmp_addr = 4'h0;
      #1;
      n_checks++; if (bus.hold_out !== 1'b1) begin n_fail++; $display("FAIL evict_remiss got %b want 1", bus.hold_out); end
      test_fill(8'h00);
      bus.jmp = 1'b0;
   endtask

   task automatic test_no_jump();
      bus.jmp_nz = 1'b1; bus.dont_jmp = 1'b1; bus.jmp_addr = 4'h4;
      #1;
      n_checks++; if (bus.hold_out !== 1'b0) begin n_fail++; $display("FAIL nojmp_hold got %b want 0", bus.hold_out); end
      cyc();
      n_checks++; if (bus.pc !== 8'h01) begin n_fail++; $display("FAIL nojmp_pc got %h want 01", bus.pc); end
      bus.dont_jmp = 1'b0; bus.jmp_addr = 4'h0;
      #1;
      n_checks++; if (bus.hold_out !== 1'b0) begin n_fail++; $display("FAIL jnz_hold got %b want 0", bus.hold_out); end
      cyc();
      n_checks++; if (bus.pc !== 8'h00) begin n_fail++; $display("FAIL jnz_pc got %h want 00", bus.pc); end
      bus.jmp_nz = 1'b0;
   endtask

   task automatic test_sync_reset_mid_fill();
      bus.jmp = 1'b1; bus.jmp_addr = 4'hC;
      #1;
      n_checks++; if (bus.hold_out !== 1'b1) begin n_fail++; $display("FAIL sr_miss got %b want 1", bus.hold_out); end
      repeat (11) cyc();
      n_checks++; if (bus.rom_address !== 8'hCA) begin n_fail++; $display("FAIL sr_rom got %h want ca", bus.rom_address); end
      n_checks++; if (bus.cache_wren !== 1'b1) begin n_fail++; $display("FAIL sr_wren_before got %b want 1", bus.cache_wren); end
      n_checks++; if (bus.cache_wroffset !== 6'h09) begin n_fail++; $display("FAIL sr_wroff got %h want 09", bus.cache_wroffset); end
      bus.sync_reset = 1'b1; bus.jmp = 1'b0;
      #1;
      n_checks++; if (bus.hold_out !== 1'b1) begin n_fail++; $display("FAIL sr_hold got %b want 1", bus.hold_out); end
      cyc();
      n_checks++; if (bus.cache_wren !== 1'b0) begin n_fail++; $display("FAIL sr_wren_after got %b want 0", bus.cache_wren); end
      n_checks++; if (bus.pc !== 8'h00) begin n_fail++; $display("FAIL sr_pc got %h want 00", bus.pc); end
      bus.sync_reset = 1'b0;
      #1;
      test_fill(8'h00);
`ifdef PS_MISS_COUNT_EN
      n_checks++; if (bus.miss_count !== 16'h0001) begin n_fail++; $display("FAIL sr_miss_count got %h want 0001", bus.miss_count); end
`endif
   endtask

   task automatic test_async_reset_mid_fill();
      bus.jmp = 1'b1; bus.jmp_addr = 4'h4;
      #1;
      n_checks++; if (bus.hold_out !== 1'b1) begin n_fail++; $display("FAIL ar_miss got %b want 1", bus.hold_out); end
      repeat (5) cyc();
      #2 reset_n = 1'b0;
      #1;
      n_checks++; if (bus.cache_wren !== 1'b0) begin n_fail++; $display("FAIL ar_wren got %b want 0", bus.cache_wren); end
      n_checks++; if (bus.pc !== 8'h00) begin n_fail++; $display("FAIL ar_pc got %h want 00", bus.pc); end
      n_checks++; if (bus.hold_out !== 1'b1) begin n_fail++; $display("FAIL ar_hold got %b want 1", bus.hold_out); end
      bus.jmp = 1'b0;
      cyc();
      reset_n = 1'b1;
      #1;
      test_fill(8'h00);
`ifdef PS_MISS_COUNT_EN
      n_checks++; if (bus.miss_count !== 16'h0001) begin n_fail++; $display("FAIL ar_miss_count got %h want 0001", bus.miss_count); end
`endif
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_jump_resident();
      test_evict();
      test_no_jump();
      test_sync_reset_mid_fill();
      test_async_reset_mid_fill();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
